led_fade_driver: RTL
====================

Name: led_fade_driver

Overview:
- Downstream stage of the 1-bit LED output PIO. It consumes the PIO's out_port level and drives the physical LED pin.
- When enabled, it applies PWM dimming with a linear fade-in and fade-out instead of a hard on/off.
- Sits between the Avalon PIO slave and the board LED pin, in the same clock domain as the PIO.

Parameters:
- PWM_BITS, 8, width of the PWM counter and the duty register. The PWM period is 2^PWM_BITS cycles.
- PRESCALE, 50000, number of clk cycles per fade step. Must be >= 1.

Ports:
- clk  in  1  system clock, same clock as the PIO.
- reset  in  1  synchronous, active-high reset.
- led_in  in  1  requested LED level, driven by the PIO out_port.
- fade_en  in  1  1 = ramp the duty gradually; 0 = step the duty immediately.
- led_out  out  1  PWM-modulated LED pin drive, registered.
- busy  out  1  high while a ramp is in progress.
- duty_level  out  PWM_BITS  current duty value, for debug or readback.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: state OFF, duty 0, pwm_cnt 0, prescale count 0, led_out 0, busy 0, duty_level 0. An asserted reset overrides everything, including a ramp in progress.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps to 0.
  - Asserts internal step_tick for one cycle when the count equals PRESCALE-1.
  - Free-running; it is not restarted by led_in changes.
  - With PRESCALE=1, step_tick is high every cycle.
- PWM counter: free-running PWM_BITS-bit up-counter that wraps from 2^PWM_BITS-1 to 0.
- Output compare:
  - pwm_on = 1 if duty is all-ones (solid full-on, no dropout cycle); otherwise pwm_on = (pwm_cnt < duty).
  - duty = 0 gives a constant 0.
  - led_out is pwm_on registered, so it lags duty and pwm_cnt by 1 cycle.
- FSM states: OFF, RAMP_UP, ON, RAMP_DOWN.
  - OFF (duty = 0): if led_in = 1 and fade_en = 1, go to RAMP_UP. If led_in = 1 and fade_en = 0, set duty to all-ones and go to ON on the next edge.
  - RAMP_UP: on each step_tick, duty increments by 1. When duty reaches all-ones, go to ON in the same edge.
  - ON (duty = all-ones): if led_in = 0 and fade_en = 1, go to RAMP_DOWN. If led_in = 0 and fade_en = 0, set duty to 0 and go to OFF.
  - RAMP_DOWN: on each step_tick, duty decrements by 1. When duty reaches 0, go to OFF.
- Reversal mid-ramp: led_in going to 0 in RAMP_UP moves to RAMP_DOWN (and vice versa) with duty unchanged. There is no jump and no wait for ramp completion.
- fade_en deasserted mid-ramp: on the next edge, duty snaps to the target for the current led_in (all-ones or 0), and the FSM goes to ON or OFF.
- Saturation: duty never wraps. No increment at all-ones, no decrement at 0.
- Simultaneous step_tick and led_in reversal: direction changes and that tick is applied in the new direction.
- busy = 1 exactly in RAMP_UP and RAMP_DOWN. It is registered together with the state.
- duty_level = duty register, with no added latency.
- A full ramp takes 2^PWM_BITS-1 ticks. The first tick arrives 1..PRESCALE cycles after entry, depending on the free-running prescaler phase.

Decomposition:
- Package led_fade_pkg holds:
  - the state enum (OFF, RAMP_UP, ON, RAMP_DOWN);
  - a function computing duty-max from PWM_BITS;
  - default parameter constants.
- Sub-module led_tick_gen: the parameterised PRESCALE counter producing step_tick.
- The PWM counter, compare logic and FSM stay in led_fade_driver.

Test Plan:
All tests use PWM_BITS=4, PRESCALE=4.
- Reset: assert reset for 3 cycles with led_in=1 → led_out=0, busy=0, duty_level=0 throughout. After release with fade_en=1, busy rises 1 cycle later.
- Full fade-up: fade_en=1, led_in 0→1 → duty_level rises 1,2,…,15 with exactly 4 cycles between steps. busy drops when duty_level=15. led_out then stays constant 1.
- PWM shape: force a hold at duty 5 (fade_en=0 steady state via a stub, or sample during the ramp) → in each 16-cycle period, led_out is high for exactly 5 cycles, delayed 1 cycle after pwm_cnt.
- Mid-ramp reversal: led_in 0→1, then 1→0 when duty_level=7 → duty_level goes 7,6,…,0 with no jump. The FSM ends in OFF and busy drops.
- Immediate mode: fade_en=0, led_in 0→1 → duty_level=15 on the next edge and busy stays 0. led_in 1→0 → duty_level=0 next edge and led_out=0 one cycle later.
- fade_en cut mid-ramp: ramp up to duty 9, then fade_en=0 → duty_level=15 next edge, state ON, busy=0.

Source files
------------

// File: rtl/led_fade_pkg.sv
// Shared types and constants for the LED fade driver.
package led_fade_pkg;

   // Default parameter values for the fade driver.
   localparam int unsigned DefPwmBits  = 8;
   localparam int unsigned DefPrescale = 50000;

   // Fade controller states.
   typedef enum logic [1:0] {
      StOff,
      StRampUp,
      StOn,
      StRampDown
   } fade_state_e;

   // All-ones duty value for a given PWM width.
   function automatic int unsigned duty_max(input int unsigned bits);
      return (32'd1 << bits) - 32'd1;
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler producing a one-cycle fade step tick.
module led_tick_gen
   import led_fade_pkg::*;
#(
   parameter int unsigned PRESCALE = DefPrescale
) (
   input  logic i_clk,
   input  logic i_reset,
   output logic o_step_tick
);

   // A single-cycle prescaler still needs a 1-bit counter to keep widths legal.
   localparam int unsigned CntW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);

   logic [CntW-1:0] r_cnt;
   logic            w_wrap;

   assign w_wrap      = (r_cnt == CntMax);
   assign o_step_tick = w_wrap;

   // Count 0..PRESCALE-1 and wrap; never restarted by LED activity.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt <= '0;
      end else if (w_wrap) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/led_fade_driver.sv
// PWM LED driver with linear fade-in/fade-out between the PIO and the LED pin.
module led_fade_driver
   import led_fade_pkg::*;
#(
   parameter int unsigned PWM_BITS = DefPwmBits,
   parameter int unsigned PRESCALE = DefPrescale
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_led_in,
   input  logic                i_fade_en,
   output logic                o_led_out,
   output logic                o_busy,
   output logic [PWM_BITS-1:0] o_duty_level
);

   localparam logic [PWM_BITS-1:0] DutyMax = PWM_BITS'(duty_max(PWM_BITS));

   fade_state_e         r_state;
   logic [PWM_BITS-1:0] r_duty;
   logic [PWM_BITS-1:0] r_pwm_cnt;
   logic                r_led_out;
   logic                r_busy;

   logic                w_step_tick;
   logic                w_pwm_on;
   logic [PWM_BITS-1:0] w_target;
   logic [PWM_BITS-1:0] w_duty_ramp;

   led_tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick_gen (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .o_step_tick (w_step_tick)
   );

   // Full duty is solid on; otherwise compare against the free-running counter.
   assign w_pwm_on = (r_duty == DutyMax) || (r_pwm_cnt < r_duty);

   assign w_target = i_led_in ? DutyMax : '0;

   // Duty after this cycle's tick, stepped toward the current request and saturated.
   always_comb begin
      w_duty_ramp = r_duty;
      if (w_step_tick) begin
         if (i_led_in) begin
            if (r_duty != DutyMax) begin
               w_duty_ramp = r_duty + 1'b1;
            end
         end else begin
            if (r_duty != '0) begin
               w_duty_ramp = r_duty - 1'b1;
            end
         end
      end
   end

   // Free-running PWM counter and registered pin drive.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pwm_cnt <= '0;
         r_led_out <= 1'b0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + 1'b1;
         r_led_out <= w_pwm_on;
      end
   end

   // Fade FSM: state, duty and busy are updated together.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= StOff;
         r_duty  <= '0;
         r_busy  <= 1'b0;
      end else begin
         unique case (r_state)
            StOff: begin
               if (i_led_in) begin
                  if (i_fade_en) begin
                     r_state <= StRampUp;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= StOn;
                     r_duty  <= DutyMax;
                  end
               end
            end
            StOn: begin
               if (!i_led_in) begin
                  if (i_fade_en) begin
                     r_state <= StRampDown;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= StOff;
                     r_duty  <= '0;
                  end
               end
            end
            StRampUp, StRampDown: begin
               if (!i_fade_en) begin
                  // Fading cut off: snap straight to the requested level.
                  r_duty  <= w_target;
                  r_state <= i_led_in ? StOn : StOff;
                  r_busy  <= 1'b0;
               end else begin
                  // Direction follows led_in, so a reversal keeps duty and applies any tick.
                  r_duty <= w_duty_ramp;
                  if (w_duty_ramp == w_target) begin
                     r_state <= i_led_in ? StOn : StOff;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= i_led_in ? StRampUp : StRampDown;
                     r_busy  <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign o_led_out    = r_led_out;
   assign o_busy       = r_busy;
   assign o_duty_level = r_duty;

endmodule
